data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
Memory-side responder for the load/store requests issued by the data-movement unit. It accepts one word request at a time (LDW read or STW write), applies a configurable wait-state latency, performs the access on an internal word RAM, and returns read data or an error flag over a valid/ready response channel. Sits between the data-movement unit and data storage. Every accepted request produces exactly one response.

Parameters:
DEPTH, 256, number of 32-bit words; addressable byte range is 0 .. 4*DEPTH-1
LATENCY, 2, wait-state cycles between request acceptance and response; 0 is legal
AW, 8, word-index width, equal to clog2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request; high only in IDLE
req_read  in  2  read code: 2'b01 read memory, 2'b10 read regs, 2'b00 no read
req_write  in  2  write code: 2'b01 write memory, 2'b10 write regs, 2'b00 no write
req_addr  in  32  byte address
req_wdata  in  32  store data
resp_valid  out  1  response present; held until taken
resp_ready  in  1  consumer takes response
resp_rdata  out  32  load data; 0 for writes and for errors
resp_err  out  1  request faulted

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; req_ready=1 after release; resp_valid=0, resp_rdata=0, resp_err=0; wait counter=0. RAM contents are not reset.
- Reset mid-operation: the pending request is discarded, no RAM write is committed, and no response is issued.
- FSM states IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, the request fields (read code, write code, addr, wdata) are registered.
  - If LATENCY=0, next state is RESP.
  - Otherwise next state is WAIT, with counter=LATENCY-1.
- WAIT: req_ready=0. Counter decrements each cycle. At counter=0, the access executes on that edge and the next state is RESP.
- Access/classification happens on the edge entering RESP:
  - Error if req_addr[1:0]!=0, or req_addr>>2 >= DEPTH.
  - Error if both codes are 2'b01.
  - Error if neither code is 2'b01 (register-only or no-op requests are not memory ops).
  - On error: resp_err=1, resp_rdata=0, RAM untouched.
  - Read (req_read=2'b01): resp_rdata=RAM[addr>>2].
  - Write (req_write=2'b01): RAM[addr>>2]=wdata; resp_rdata=0.
- RESP: resp_valid=1. resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
  - On resp_valid && resp_ready, next state is IDLE and resp_valid, resp_rdata, resp_err clear to 0.
- Latency: with resp_ready held high, resp_valid rises LATENCY+1 cycles after the acceptance edge. Minimum turnaround is LATENCY+2 cycles per request.
- Requests presented while not in IDLE are not accepted; the requester holds them.
- Back-to-back: a read of an address immediately after a write to the same address returns the new data.
- Address arithmetic: the word index is addr[AW+1:2]. The range check uses the full 32 bits, so aliasing is not permitted.

Decomposition:
- Package data_mem_pkg holds:
  - Code constants: OP_NONE=2'b00, OP_MEM=2'b01, OP_REG=2'b10.
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - The LDW/STW/MV opcode constants, shared with the data-movement unit.
- One sub-module, data_mem_ram: single-port synchronous RAM, DEPTH x 32, with write enable and registered read. The responder instantiates it and drives it on the access edge.

Test Plan:
- Write then read: write 0xDEADBEEF to 0x10, then read 0x10 (LATENCY=2, resp_ready=1) -> write response err=0, rdata=0; read response err=0, rdata=0xDEADBEEF; resp_valid rises 3 cycles after each acceptance.
- Misaligned write: write 0x12345678 to 0x13 -> err=1, rdata=0; a following read of 0x10 still returns the prior value 0xDEADBEEF.
- Out of range: read at 0x400 with DEPTH=256 -> err=1. Read at 0x3FC -> err=0.
- Illegal codes: req_read=01 with req_write=01 -> err=1 and no RAM change. req_read=10 with req_write=00 -> err=1, exactly one response.
- Backpressure: hold resp_ready=0 for 4 cycles after a read response appears -> resp_valid, resp_rdata and resp_err stay constant and req_ready stays 0; raise resp_ready -> IDLE next cycle, req_ready=1.
- Reset mid-operation: pulse rst_n low during WAIT of a write of 0xCAFEF00D to 0x20 -> resp_valid stays 0; a subsequent read of 0x20 returns the pre-reset value. A separate run with LATENCY=0 shows the response one cycle after acceptance.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: request codes, responder state encoding and opcodes
// shared between the data-movement unit and the memory responder.
package data_mem_pkg;
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_REG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [5:0] OPC_LDW = 6'h20;
    localparam logic [5:0] OPC_STW = 6'h21;
    localparam logic [5:0] OPC_MV  = 6'h22;
endpackage

// File: rtl/data_mem_ram.sv
// data_mem_ram: single-port synchronous word RAM with registered read.
module data_mem_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: word load/store responder with configurable wait states;
// one response per accepted request, held until taken.
module data_mem_resp
    import data_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_read,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rd_code_q, rd_code_d, wr_code_q, wr_code_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic          is_rd_q, is_rd_d, err_q, err_d;
    logic          acc, acc_err;
    logic [1:0]    a_rd, a_wr;
    logic [31:0]   a_addr, a_wdata, ram_rdata;

    // With zero wait states the access happens on the acceptance edge itself,
    // so it must use the live request rather than the registered copy.
    always_comb begin
        a_rd    = (LATENCY == 0) ? req_read  : rd_code_q;
        a_wr    = (LATENCY == 0) ? req_write : wr_code_q;
        a_addr  = (LATENCY == 0) ? req_addr  : addr_q;
        a_wdata = (LATENCY == 0) ? req_wdata : wdata_q;
        acc_err = (a_addr[1:0] != 2'b00) || ((a_addr >> 2) >= 32'(DEPTH))
                  || ((a_rd == OP_MEM) == (a_wr == OP_MEM));
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_code_d = rd_code_q;
        wr_code_d = wr_code_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        err_d     = err_q;
        acc       = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                rd_code_d = req_read;
                wr_code_d = req_write;
                addr_d    = req_addr;
                wdata_d   = req_wdata;
                if (LATENCY == 0) begin
                    acc     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: if (cnt_q == '0) begin
                acc     = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (resp_ready) begin
                state_d = IDLE;
                is_rd_d = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (acc) begin
            err_d   = acc_err;
            is_rd_d = !acc_err && (a_rd == OP_MEM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_code_q <= OP_NONE;
            wr_code_q <= OP_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_rd_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_code_q <= rd_code_d;
            wr_code_q <= wr_code_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            err_q     <= err_d;
        end
    end

    // Gating with rst_n keeps a held request from committing a write during reset.
    data_mem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .en    (acc && !acc_err && rst_n),
        .we    (a_wr == OP_MEM),
        .addr  (a_addr[AW+1:2]),
        .wdata (a_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign resp_rdata = is_rd_q ? ram_rdata : 32'd0;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed plus randomized checks of two responders
// (LATENCY=2 and LATENCY=0) against an array-based memory model.
module tb_data_mem_resp;
    import data_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstn [2];
    logic        rv   [2];
    logic        rdy  [2];
    logic [1:0]  rd   [2];
    logic [1:0]  wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic        vld  [2];
    logic        rr   [2];
    logic [31:0] rdat [2];
    logic        err  [2];

    logic [31:0] mdl [2][256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH(256), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rstn[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_read(rd[0]), .req_write(wr[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
        .resp_valid(vld[0]), .resp_ready(rr[0]), .resp_rdata(rdat[0]), .resp_err(err[0])
    );

    data_mem_resp #(.DEPTH(256), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rstn[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_read(rd[1]), .req_write(wr[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
        .resp_valid(vld[1]), .resp_ready(rr[1]), .resp_rdata(rdat[1]), .resp_err(err[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full request/response exchange; expected values come from the model.
    task automatic xact(input int d, input logic [1:0] r, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] dat, input int hold);
        logic        e;
        logic [31:0] exp_rd;
        int          n;
        e = (a[1:0] != 2'b00) || (a >= 32'd1024) || ((r == OP_MEM) == (w == OP_MEM));
        exp_rd = (!e && r == OP_MEM) ? mdl[d][a[9:2]] : 32'd0;
        if (!e && w == OP_MEM) mdl[d][a[9:2]] = dat;
        @(negedge clk);
        rv[d] = 1'b1; rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = dat;
        rr[d] = (hold == 0);
        n = 0;
        while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
        check("req_ready_before_accept", 32'(rdy[d]), 32'd1);
        @(negedge clk);
        rv[d] = 1'b0;
        n = 1;
        while (!vld[d] && n < 20) begin @(negedge clk); n++; end
        check("resp_latency", n, 32'(lat(d) + 1));
        check("resp_rdata", rdat[d], exp_rd);
        check("resp_err", 32'(err[d]), 32'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(vld[d]), 32'd1);
            check("hold_rdata", rdat[d], exp_rd);
            check("hold_err", 32'(err[d]), 32'(e));
            check("hold_req_ready", 32'(rdy[d]), 32'd0);
        end
        rr[d] = 1'b1;
        @(negedge clk);
        check("after_valid", 32'(vld[d]), 32'd0);
        check("after_req_ready", 32'(rdy[d]), 32'd1);
        check("after_rdata", rdat[d], 32'd0);
        check("after_err", 32'(err[d]), 32'd0);
    endtask

    initial begin
        logic [1:0]  r, w;
        logic [31:0] a;
        int          d, k;
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; rv[i] = 1'b0; rd[i] = OP_NONE; wr[i] = OP_NONE;
            ad[i] = '0; wd[i] = '0; rr[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_req_ready", 32'(rdy[i]), 32'd1);
            check("reset_valid", 32'(vld[i]), 32'd0);
            check("reset_rdata", rdat[i], 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
        end

        xact(0, OP_NONE, OP_MEM, 32'h10, 32'hDEADBEEF, 0);
        xact(0, OP_MEM, OP_NONE, 32'h10, 32'h0, 0);
        xact(0, OP_NONE, OP_MEM, 32'h13, 32'h12345678, 0);
        xact(0, OP_MEM, OP_NONE, 32'h10, 32'h0, 0);
        xact(0, OP_NONE, OP_MEM, 32'h3FC, 32'h0BADF00D, 0);
        xact(0, OP_MEM, OP_NONE, 32'h3FC, 32'h0, 0);
        xact(0, OP_MEM, OP_NONE, 32'h400, 32'h0, 0);
        xact(0, OP_MEM, OP_MEM, 32'h10, 32'h11111111, 0);
        xact(0, OP_MEM, OP_NONE, 32'h10, 32'h0, 0);
        xact(0, OP_REG, OP_NONE, 32'h10, 32'h0, 0);
        repeat (3) begin
            @(negedge clk);
            check("single_response", 32'(vld[0]), 32'd0);
        end
        xact(0, OP_NONE, OP_MEM, 32'h20, 32'hA5A5A5A5, 0);
        xact(0, OP_MEM, OP_NONE, 32'h10, 32'h0, 4);

        // Reset while the write sits in WAIT: nothing commits, nothing responds.
        @(negedge clk);
        check("midrst_ready", 32'(rdy[0]), 32'd1);
        rv[0] = 1'b1; rd[0] = OP_NONE; wr[0] = OP_MEM; ad[0] = 32'h20; wd[0] = 32'hCAFEF00D;
        @(negedge clk);
        rv[0] = 1'b0;
        check("midrst_in_wait", 32'(rdy[0]), 32'd0);
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_resp", 32'(vld[0]), 32'd0);
        end
        xact(0, OP_MEM, OP_NONE, 32'h20, 32'h0, 0);

        xact(1, OP_NONE, OP_MEM, 32'h40, 32'h13579BDF, 0);
        xact(1, OP_MEM, OP_NONE, 32'h40, 32'h0, 0);
        xact(1, OP_MEM, OP_NONE, 32'h41, 32'h0, 2);

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++)
                xact(i, OP_NONE, OP_MEM, 32'h100 + 32'(j * 4), $urandom, 0);

        for (int it = 0; it < 80; it++) begin
            d = $urandom_range(0, 1);
            r = 2'($urandom_range(0, 2));
            w = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 1) begin r = OP_MEM; w = 2'($urandom_range(0, 1) * 2); end
                else begin w = OP_MEM; r = 2'($urandom_range(0, 1) * 2); end
            end
            k = $urandom_range(0, 9);
            a = 32'h100 + 32'($urandom_range(0, 7) * 4);
            if (k == 8) a = a + 32'($urandom_range(1, 3));
            if (k == 9) a = 32'h400 + 32'($urandom_range(0, 1000) * 4);
            xact(d, r, w, a, $urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
